// File: rtl/seven_seg_scan_driver_if.sv
// User-side / pin-side bundle for the seven-segment scan driver.
// master = user logic driving the display data, slave = the driver itself.
interface seven_seg_scan_driver_if #(
  parameter int NUM_DIGITS = 8
);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   en_in;
  logic                    lz_suppress;
  logic [NUM_DIGITS-1:0]   anode;
  logic [6:0]              seg;
  logic                    dp_out;
  logic                    update_pend;
  logic                    frame_done;

  modport master (
    output load, digits_in, dp_in, en_in, lz_suppress,
    input  anode, seg, dp_out, update_pend, frame_done
  );

  modport slave (
    input  load, digits_in, dp_in, en_in, lz_suppress,
    output anode, seg, dp_out, update_pend, frame_done
  );
endinterface

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed seven-segment scanner with double-buffered digit data,
// per-digit enable, leading-zero suppression and an anti-ghosting blank interval.
//
// state    | meaning
// ST_BLANK | start of a digit slot, every anode off
// ST_SHOW  | selected anode on, segments show the current digit
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS     = 8,
  parameter int CLK_DIV        = 100000,
  parameter int BLANK_CYCLES   = 16,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input logic                   clk,
  input logic                   rst_n,
  seven_seg_scan_driver_if.slave bus
);
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_LAST = DIV_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF = (AN_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = (SEG_ACTIVE_LOW != 0);

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t                  state_q;
  logic [DIV_W-1:0]        div_q;
  logic [IDX_W-1:0]        idx_q;
  logic [4*NUM_DIGITS-1:0] disp_code_q, pend_code_q;
  logic [NUM_DIGITS-1:0]   disp_dp_q, pend_dp_q, disp_en_q, pend_en_q;
  logic                    update_pend_q, frame_done_q;
  logic [NUM_DIGITS-1:0]   anode_q;
  logic [6:0]              seg_q;
  logic                    dp_q;

  logic                    slot_end, boundary;
  logic [3:0]              cur_code;
  logic [6:0]              lit_d;
  logic                    dp_lit;
  logic [NUM_DIGITS-1:0]   sel;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic                    zero_run;

  function automatic logic [6:0] decode(input logic [3:0] code);
    case (code)
      4'h0: decode = 7'b1111110;
      4'h1: decode = 7'b0110000;
      4'h2: decode = 7'b1101101;
      4'h3: decode = 7'b1111001;
      4'h4: decode = 7'b0110011;
      4'h5: decode = 7'b1011011;
      4'h6: decode = 7'b1011111;
      4'h7: decode = 7'b1110000;
      4'h8: decode = 7'b1111111;
      4'h9: decode = 7'b1110011;
      4'hA: decode = 7'b0000001;
      4'hB: decode = 7'b0111110;
      default: decode = 7'b0000000;
    endcase
  endfunction

  assign slot_end = (div_q == DIV_LAST);
  assign boundary = slot_end && (idx_q == IDX_LAST);
  assign cur_code = disp_code_q[{idx_q, 2'b00} +: 4];

  // A digit is a leading zero when it and every digit to its left hold code 0.
  always_comb begin
    zero_run = 1'b1;
    lz_blank = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run    = zero_run && (disp_code_q[4*k +: 4] == 4'h0);
      lz_blank[k] = zero_run && (k != 0);
    end
  end

  always_comb begin
    lit_d = decode(cur_code);
    if (!disp_en_q[idx_q] || (bus.lz_suppress && lz_blank[idx_q])) lit_d = '0;
    dp_lit = disp_dp_q[idx_q] & disp_en_q[idx_q];
    sel = '0;
    sel[idx_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_BLANK;
      div_q         <= '0;
      idx_q         <= '0;
      disp_code_q   <= '1;
      pend_code_q   <= '1;
      disp_dp_q     <= '0;
      pend_dp_q     <= '0;
      disp_en_q     <= '0;
      pend_en_q     <= '0;
      update_pend_q <= 1'b0;
      frame_done_q  <= 1'b0;
      anode_q       <= AN_OFF;
      seg_q         <= SEG_OFF;
      dp_q          <= DP_OFF;
    end else begin
      div_q        <= slot_end ? '0 : div_q + 1'b1;
      frame_done_q <= boundary;
      if (slot_end) idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

      case (state_q)
        ST_BLANK: if (BLANK_CYCLES == 0 || div_q == BLANK_LAST) state_q <= ST_SHOW;
        ST_SHOW:  if (slot_end && BLANK_CYCLES != 0) state_q <= ST_BLANK;
        default:  state_q <= ST_BLANK;
      endcase

      // A load landing on the boundary bypasses the pending buffer entirely.
      if (boundary) begin
        if (bus.load) begin
          disp_code_q <= bus.digits_in;
          disp_dp_q   <= bus.dp_in;
          disp_en_q   <= bus.en_in;
        end else if (update_pend_q) begin
          disp_code_q <= pend_code_q;
          disp_dp_q   <= pend_dp_q;
          disp_en_q   <= pend_en_q;
        end
        update_pend_q <= 1'b0;
      end else if (bus.load) begin
        pend_code_q   <= bus.digits_in;
        pend_dp_q     <= bus.dp_in;
        pend_en_q     <= bus.en_in;
        update_pend_q <= 1'b1;
      end

      if (state_q == ST_SHOW) begin
        anode_q <= sel ^ AN_OFF;
        seg_q   <= lit_d ^ SEG_OFF;
        dp_q    <= dp_lit ^ DP_OFF;
      end else begin
        anode_q <= AN_OFF;
        seg_q   <= SEG_OFF;
        dp_q    <= DP_OFF;
      end
    end
  end

  assign bus.anode       = anode_q;
  assign bus.seg         = seg_q;
  assign bus.dp_out      = dp_q;
  assign bus.update_pend = update_pend_q;
  assign bus.frame_done  = frame_done_q;
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver: 4 digits, 4-cycle slots, 1-cycle blank,
// active-low segments and anodes; expected pin patterns are hand-computed per frame.
module tb_seven_seg_scan_driver;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  seven_seg_scan_driver_if #(.NUM_DIGITS(4)) bus ();

  seven_seg_scan_driver #(
    .NUM_DIGITS(4), .CLK_DIV(4), .BLANK_CYCLES(1), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tickn(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts right after a frame boundary edge; checks 16 cycles of pins.
  // s3..s0 are logical (1 = lit) patterns per digit, dpm the logical dp per digit.
  task automatic check_frame(input string tag, input logic [6:0] s3, input logic [6:0] s2,
                             input logic [6:0] s1, input logic [6:0] s0, input logic [3:0] dpm);
    logic [6:0] s [4];
    logic [3:0] an;
    logic [6:0] sg;
    logic       dd, fd;
    int         p, ix, d;
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    for (int j = 1; j <= 16; j++) begin
      tick();
      p  = j - 1;
      ix = p / 4;
      d  = p % 4;
      an = 4'hF;
      sg = 7'h7F;
      dd = 1'b1;
      if (d >= 1) begin
        an[ix] = 1'b0;
        sg = ~s[ix];
        dd = ~dpm[ix];
      end
      fd = (j == 16);
      chk($sformatf("%s[%0d]", tag, j),
          {19'b0, bus.anode, bus.seg, bus.dp_out, bus.frame_done},
          {19'b0, an, sg, dd, fd});
    end
  endtask

  task automatic load_and_wait(input string tag, input logic [15:0] dig, input logic [3:0] en,
                               input logic [3:0] dp);
    bus.digits_in = dig;
    bus.en_in     = en;
    bus.dp_in     = dp;
    bus.load      = 1'b1;
    tick();
    bus.load = 1'b0;
    chk({tag, "_pend_set"}, {31'b0, bus.update_pend}, 32'd1);
    tickn(15);
    chk({tag, "_pend_clr"}, {31'b0, bus.update_pend}, 32'd0);
  endtask

  initial begin
    bus.load        = 1'b0;
    bus.digits_in   = '0;
    bus.dp_in       = '0;
    bus.en_in       = '0;
    bus.lz_suppress = 1'b0;

    // 1: reset values, then two blank frames
    tickn(2);
    chk("rst_pins", {19'b0, bus.anode, bus.seg, bus.dp_out, bus.frame_done},
        {19'b0, 4'hF, 7'h7F, 1'b1, 1'b0});
    chk("rst_pend", {31'b0, bus.update_pend}, 32'd0);
    rst_n = 1'b1;
    check_frame("blank0", 7'h00, 7'h00, 7'h00, 7'h00, 4'b0000);
    check_frame("blank1", 7'h00, 7'h00, 7'h00, 7'h00, 4'b0000);

    // 2: 4321 with dp on digit 1
    load_and_wait("ld4321", 16'h4321, 4'hF, 4'b0010);
    check_frame("f4321", 7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000, 4'b0010);

    // enable mask blanks digit 3 and its dp
    load_and_wait("ld9876", 16'h9876, 4'b0111, 4'b1111);
    check_frame("f9876", 7'b0000000, 7'b1111111, 7'b1110000, 7'b1011111, 4'b0111);

    // 3: leading-zero suppression
    bus.lz_suppress = 1'b1;
    load_and_wait("ld0070", 16'h0070, 4'hF, 4'b0000);
    check_frame("f0070", 7'b0000000, 7'b0000000, 7'b1110000, 7'b1111110, 4'b0000);
    load_and_wait("ld0000", 16'h0000, 4'hF, 4'b0000);
    check_frame("f0000", 7'b0000000, 7'b0000000, 7'b0000000, 7'b1111110, 4'b0000);
    bus.lz_suppress = 1'b0;

    // 4: two loads in one frame, last wins
    bus.digits_in = 16'h1111;
    bus.en_in     = 4'hF;
    bus.dp_in     = 4'b0000;
    bus.load      = 1'b1;
    tick();
    bus.load = 1'b0;
    chk("dbl_pend1", {31'b0, bus.update_pend}, 32'd1);
    tickn(3);
    bus.digits_in = 16'hAB00;
    bus.load      = 1'b1;
    tick();
    bus.load = 1'b0;
    chk("dbl_pend2", {31'b0, bus.update_pend}, 32'd1);
    tickn(11);
    chk("dbl_pend_clr", {31'b0, bus.update_pend}, 32'd0);
    check_frame("fAB00", 7'b0000001, 7'b0111110, 7'b1111110, 7'b1111110, 4'b0000);

    // 5: load exactly on the boundary edge
    tickn(15);
    bus.digits_in = 16'h2590;
    bus.en_in     = 4'hF;
    bus.dp_in     = 4'b1000;
    bus.load      = 1'b1;
    tick();
    bus.load = 1'b0;
    chk("bnd_pend", {31'b0, bus.update_pend}, 32'd0);
    chk("bnd_fdone", {31'b0, bus.frame_done}, 32'd1);
    check_frame("f2590", 7'b1101101, 7'b1011011, 7'b1110011, 7'b1111110, 4'b1000);

    // 6: async reset while digit 2 is shown
    tickn(10);
    chk("pre_rst_an", {28'b0, bus.anode}, 32'hB);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst", {18'b0, bus.anode, bus.seg, bus.dp_out, bus.frame_done, bus.update_pend},
        {18'b0, 4'hF, 7'h7F, 1'b1, 1'b0, 1'b0});
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_blank", {28'b0, bus.anode}, 32'hF);
    tick();
    chk("post_rst_an0", {19'b0, bus.anode, bus.seg, bus.dp_out, bus.frame_done},
        {19'b0, 4'hE, 7'h7F, 1'b1, 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
